satd_diff_sequencer: RTL and testbench

//  Row sequencer for the SATD difference stage: on start, reads BLK_H rows of original and current

---
 rtl/satd_diff_sequencer_pkg.sv | 24 ++
 rtl/satd_diff_sequencer_if.sv | 35 +++
 rtl/satd_diff_sequencer_pixel_diff.sv | 11 +
 rtl/satd_diff_sequencer.sv | 121 ++++++++++++
 tb/tb_satd_diff_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/satd_diff_sequencer_pkg.sv
// Shared constants, FSM state encoding and lane-slicing helper for the
// SATD difference stage.
package satd_pkg;

   localparam int PIX_W  = 8;
   localparam int DIFF_W = PIX_W + 1;
   localparam int BLK_W  = 4;
   localparam int BLK_H  = 4;
   localparam int ADDR_W = 6;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      OUT  = 3'd3,
      DONE = 3'd4
   } seq_state_t;

   // Low bit index of lane 'lane' in a flat vector of 'width'-bit lanes.
   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/satd_diff_sequencer_if.sv
// Row-buffer read port and difference-row stream of the SATD difference
// stage. master = sequencer side, slave = buffers / transform side.
interface satd_diff_sequencer_if #(
   parameter int PIX_W  = satd_pkg::PIX_W,
   parameter int BLK_W  = satd_pkg::BLK_W,
   parameter int BLK_H  = satd_pkg::BLK_H,
   parameter int ADDR_W = satd_pkg::ADDR_W
);
   localparam int DIFF_W = PIX_W + 1;
   localparam int ROW_W  = (BLK_H > 1) ? $clog2(BLK_H) : 1;

   logic                    mem_rd_en;
   logic [ADDR_W-1:0]       mem_addr;
   logic [BLK_W*PIX_W-1:0]  org_row;
   logic [BLK_W*PIX_W-1:0]  cur_row;
   logic                    out_valid;
   logic                    out_ready;
   logic [BLK_W*DIFF_W-1:0] out_diff;
   logic [ROW_W-1:0]        out_row;
   logic                    out_last;

   modport master (
      output mem_rd_en, mem_addr,
      input  org_row, cur_row,
      output out_valid, out_diff, out_row, out_last,
      input  out_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr,
      output org_row, cur_row,
      input  out_valid, out_diff, out_row, out_last,
      output out_ready
   );
endinterface

// File: rtl/satd_diff_sequencer_pixel_diff.sv
// One combinational difference lane: zero-extended org minus cur, which
// always fits in PIX_W+1 signed bits.
module pixel_diff #(
   parameter int PIX_W = satd_pkg::PIX_W
) (
   input  logic              [PIX_W-1:0] org,
   input  logic              [PIX_W-1:0] cur,
   output logic signed       [PIX_W:0]   diff
);
   assign diff = $signed({1'b0, org}) - $signed({1'b0, cur});
endmodule

// File: rtl/satd_diff_sequencer.sv
// Row sequencer for the SATD difference stage: reads BLK_H rows from the
// org/cur block buffers, forms BLK_W signed lane differences per row and
// streams them to the Hadamard stage under valid/ready.
module satd_diff_sequencer #(
   parameter int PIX_W  = satd_pkg::PIX_W,
   parameter int BLK_W  = satd_pkg::BLK_W,
   parameter int BLK_H  = satd_pkg::BLK_H,
   parameter int ADDR_W = satd_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] blk_base,
   output logic              busy,
   output logic              done,
   satd_diff_sequencer_if.master bus
);
   import satd_pkg::*;

   localparam int DIFF_W = PIX_W + 1;
   localparam int ROW_W  = (BLK_H > 1) ? $clog2(BLK_H) : 1;

   localparam logic [2:0] ST_IDLE = IDLE;
   localparam logic [2:0] ST_RD   = RD;
   localparam logic [2:0] ST_CAP  = CAP;
   localparam logic [2:0] ST_OUT  = OUT;
   localparam logic [2:0] ST_DONE = DONE;

   logic [2:0]              state;
   logic [ADDR_W-1:0]       base;
   logic [ROW_W-1:0]        row_cnt;
   logic                    hs;
   logic                    last_row;
   logic                    rd_en;

   logic signed [DIFF_W-1:0] lane_diff_p0 [BLK_W];
   logic [BLK_W*DIFF_W-1:0]  diff_flat_p0;
   logic [BLK_W*DIFF_W-1:0]  diff_p1;
   logic [ROW_W-1:0]         row_p1;
   logic                     last_p1;

   // ---- stage p0: combinational lane differences of the returned row ----
   for (genvar i = 0; i < BLK_W; i++) begin : g_lane
      localparam int PLO = lane_lo(i, PIX_W);
      localparam int DLO = lane_lo(i, DIFF_W);
      pixel_diff #(.PIX_W(PIX_W)) u_diff (
         .org  (bus.org_row[PLO +: PIX_W]),
         .cur  (bus.cur_row[PLO +: PIX_W]),
         .diff (lane_diff_p0[i])
      );
      assign diff_flat_p0[DLO +: DIFF_W] = lane_diff_p0[i];
   end

   assign hs       = (state == ST_OUT) && bus.out_ready;
   assign last_row = (row_cnt == ROW_W'(BLK_H - 1));

   // Read strobe: the RD state, or the next row fetched in the handshake cycle.
   always_comb begin
      rd_en        = 1'b0;
      bus.mem_addr = '0;
      if (!abort && ((state == ST_RD) || (hs && !last_row)))
         rd_en = 1'b1;
      if (rd_en)
         bus.mem_addr = base + ADDR_W'(row_cnt) + ADDR_W'(state == ST_OUT);
   end

   assign bus.mem_rd_en = rd_en;
   assign bus.out_valid = (state == ST_OUT);
   assign busy          = (state != ST_IDLE);
   assign done          = (state == ST_DONE);

   // Control FSM; abort overrides every transition and returns to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         base    <= '0;
         row_cnt <= '0;
      end else if (abort) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               base    <= blk_base;
               row_cnt <= '0;
               state   <= ST_RD;
            end
            ST_RD:   state <= ST_CAP;
            ST_CAP:  state <= ST_OUT;
            ST_OUT:  if (hs) begin
               if (last_row) begin
                  state <= ST_DONE;
               end else begin
                  row_cnt <= row_cnt + 1'b1;
                  state   <= ST_CAP;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ---- stage p1: output row register, loaded in CAP, held through OUT ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         diff_p1 <= '0;
         row_p1  <= '0;
         last_p1 <= 1'b0;
      end else if ((state == ST_CAP) && !abort) begin
         diff_p1 <= diff_flat_p0;
         row_p1  <= row_cnt;
         last_p1 <= last_row;
      end
   end

   assign bus.out_diff = diff_p1;
   assign bus.out_row  = row_p1;
   assign bus.out_last = last_p1;

endmodule

// File: tb/tb_satd_diff_sequencer.sv
// Bench for satd_diff_sequencer: behavioural row buffers and a per-block
// expectation model built from plain integer arithmetic on the buffer contents.
module tb_satd_diff_sequencer;
   localparam int PIX_W  = 8;
   localparam int BLK_W  = 4;
   localparam int BLK_H  = 4;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] blk_base = '0;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;

   logic [31:0] org_mem [64];
   logic [31:0] cur_mem [64];

   satd_diff_sequencer_if #(.PIX_W(PIX_W), .BLK_W(BLK_W), .BLK_H(BLK_H), .ADDR_W(ADDR_W)) bus ();

   satd_diff_sequencer #(.PIX_W(PIX_W), .BLK_W(BLK_W), .BLK_H(BLK_H), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .blk_base (blk_base),
      .busy     (busy),
      .done     (done),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Block buffers: row data returned one cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.org_row <= org_mem[bus.mem_addr];
         bus.cur_row <= cur_mem[bus.mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected difference row for buffer address a: integer org - cur per lane.
   function automatic logic [35:0] exp_diff(input logic [5:0] a);
      logic [35:0] r;
      int d;
      r = '0;
      for (int i = 0; i < BLK_W; i++) begin
         d = int'(org_mem[a][i*8 +: 8]) - int'(cur_mem[a][i*8 +: 8]);
         r[i*9 +: 9] = 9'(d);
      end
      return r;
   endfunction

   // mode 0: random, 1: constant 200/50, 2: extremes (+255, -255, equal, random)
   task automatic fill(input logic [5:0] base, input int mode);
      logic [5:0] a;
      logic [7:0] e;
      for (int k = 0; k < BLK_H; k++) begin
         a = 6'(base + k);
         e = 8'($urandom);
         case (mode)
            1: begin org_mem[a] = 32'hC8C8C8C8; cur_mem[a] = 32'h32323232; end
            2: begin
               org_mem[a] = {8'($urandom), e, 8'd0,   8'd255};
               cur_mem[a] = {8'($urandom), e, 8'd255, 8'd0};
            end
            default: begin org_mem[a] = $urandom; cur_mem[a] = $urandom; end
         endcase
      end
   endtask

   task automatic run_block(input logic [5:0] base, input int stall_row, input int stall_len,
                            input int abort_row, input bit poke, input bit rand_ready);
      int rows = 0;
      int reads = 0;
      int stall = 0;
      int last_hs = -10;
      int cap_row = -1;
      bit first_seen = 0;
      bit fin = 0;
      bit aborted = 0;
      @(negedge clk);
      blk_base = base;
      start = 1'b1;
      bus.out_ready = 1'b1;
      for (int cyc = 1; cyc <= 80 && !fin; cyc++) begin
         @(negedge clk);
         start = poke && (cyc == 5);
         blk_base = start ? (base ^ 6'h2A) : base;
         abort = (abort_row >= 0) && (cap_row == abort_row);
         if (bus.out_valid && rows == stall_row && stall < stall_len) begin
            bus.out_ready = 1'b0;
            stall++;
         end else begin
            bus.out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
         end
         #1;
         if (cyc == 1) chk("busy_rise", busy, 1);
         cap_row = -1;
         if (bus.mem_rd_en) begin
            chk("mem_addr", bus.mem_addr, 6'(base + reads));
            if (bus.out_valid) chk("rd_only_on_hs", bus.out_ready, 1);
            cap_row = reads;
            reads++;
         end
         if (abort) begin
            chk("abort_cap_no_valid", bus.out_valid, 0);
            aborted = 1;
            fin = 1;
         end else if (bus.out_valid) begin
            if (!first_seen) begin
               first_seen = 1;
               chk("first_valid_lat", cyc, 3);
            end
            chk("out_row", bus.out_row, rows);
            chk("out_diff", bus.out_diff, exp_diff(6'(base + rows)));
            chk("out_last", bus.out_last, (rows == BLK_H - 1));
            if (bus.out_ready) begin
               rows++;
               last_hs = cyc;
            end
         end
         if (done && !abort) begin
            chk("done_lat", cyc - last_hs, 1);
            chk("rows_out", rows, BLK_H);
            chk("rows_read", reads, BLK_H);
            fin = 1;
         end
      end
      if (abort_row >= 0) begin
         chk("abort_taken", aborted, 1);
         @(negedge clk);
         abort = 1'b0;
         #1;
         chk("abort_busy", busy, 0);
         chk("abort_valid", bus.out_valid, 0);
         chk("abort_rd", bus.mem_rd_en, 0);
         chk("abort_hold_diff", bus.out_diff, exp_diff(6'(base + abort_row - 1)));
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("abort_no_done", done, 0);
            chk("abort_stays_idle", bus.out_valid, 0);
         end
      end else begin
         chk("block_finished", fin, 1);
         @(negedge clk);
         #1;
         chk("done_pulse_end", done, 0);
         chk("busy_fall", busy, 0);
      end
   endtask

   initial begin
      bus.out_ready = 1'b0;
      for (int a = 0; a < 64; a++) begin
         org_mem[a] = $urandom;
         cur_mem[a] = $urandom;
      end

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd", bus.mem_rd_en, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_diff", bus.out_diff, 0);
      rst = 1'b1;

      // full block, constant rows
      fill(6'd8, 1);
      run_block(6'd8, -1, 0, -1, 0, 0);

      // extremes
      fill(6'd20, 2);
      run_block(6'd20, -1, 0, -1, 0, 0);

      // backpressure on row 1
      fill(6'd30, 0);
      run_block(6'd30, 1, 5, -1, 0, 0);

      // abort in CAP of row 2, then a clean block
      fill(6'd40, 0);
      run_block(6'd40, -1, 0, 2, 0, 0);
      run_block(6'd40, -1, 0, -1, 0, 0);

      // address wrap with start poked while busy
      fill(6'd62, 0);
      run_block(6'd62, -1, 0, -1, 1, 0);

      // randomized blocks with random ready
      for (int n = 0; n < 4; n++) begin
         logic [5:0] b;
         b = 6'($urandom);
         fill(b, 0);
         run_block(b, -1, 0, -1, 0, 1);
      end

      // reset asserted mid-OUT
      fill(6'd12, 0);
      @(negedge clk);
      blk_base = 6'd12;
      start = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
      chk("reach_out", bus.out_valid, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_rd", bus.mem_rd_en, 0);
      chk("mid_rst_addr", bus.mem_addr, 0);
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_last", bus.out_last, 0);
      chk("mid_rst_row", bus.out_row, 0);
      chk("mid_rst_diff", bus.out_diff, 0);
      @(negedge clk);
      rst = 1'b1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk("post_rst_done", done, 0);
         chk("post_rst_busy", busy, 0);
      end

      // block after reset runs from row 0
      fill(6'd50, 0);
      run_block(6'd50, -1, 0, -1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
